// File: rtl/jpeg_ziguzagu_ctrl_if.sv
// Token, zigzag-register write and block handshake signals between the
// Huffman decoder, the zigzag sequencer and the IDCT stage.
interface jpeg_ziguzagu_ctrl_if;
  logic        InValid;
  logic        InReady;
  logic [3:0]  InRun;
  logic [15:0] InLevel;
  logic        InEob;
  logic        PredClear;
  logic        RegEnable;
  logic [5:0]  RegAddress;
  logic [15:0] RegData;
  logic        BlockValid;
  logic        BlockAck;
  logic        Overrun;

  // Environment side: token source and block consumer.
  modport master (
    output InValid, InRun, InLevel, InEob, PredClear, BlockAck,
    input  InReady, RegEnable, RegAddress, RegData, BlockValid, Overrun
  );

  // Sequencer side.
  modport slave (
    input  InValid, InRun, InLevel, InEob, PredClear, BlockAck,
    output InReady, RegEnable, RegAddress, RegData, BlockValid, Overrun
  );
endinterface

// File: rtl/jpeg_ziguzagu_ctrl.sv
// Zigzag block loader: turns run/level tokens into zigzag register writes
// and hands each finished 8x8 block to the IDCT with a valid/ack handshake.
// Optional DC prediction: define JPEG_ZIGUZAGU_CTRL_DCPRED_EN.
module jpeg_ziguzagu_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_ziguzagu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, FULL} state_t;

  state_t      state;
  logic [6:0]  index;
  logic [6:0]  addr_sum;
  logic        accept;
  logic [15:0] dc_value;

  logic        reg_enable;
  logic [5:0]  reg_address;
  logic [15:0] reg_data;
  logic        block_valid;
  logic        overrun;

  // Tokens are only taken while a block is being assembled; held low in reset.
  assign bus.InReady = !rst && ((state == IDLE) || (state == ACCUM));
  assign accept      = bus.InValid && bus.InReady;
  // 7-bit sum so an index past 63 is visible rather than wrapping.
  assign addr_sum    = index + {3'b000, bus.InRun};

  assign bus.RegEnable  = reg_enable;
  assign bus.RegAddress = reg_address;
  assign bus.RegData    = reg_data;
  assign bus.BlockValid = block_valid;
  assign bus.Overrun    = overrun;

`ifdef JPEG_ZIGUZAGU_CTRL_DCPRED_EN
  logic [15:0] pred;

  // A clear coincident with a DC token makes that DC use a zero predictor.
  assign dc_value = (bus.PredClear ? 16'h0000 : pred) + bus.InLevel;

  // DC predictor: tracks the last written DC value, zeroed by restart markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred <= '0;
    end else if (accept && (state == IDLE) && !bus.InEob) begin
      pred <= dc_value;
    end else if (bus.PredClear) begin
      pred <= '0;
    end
  end
`else
  logic unused_pred_clear;

  assign dc_value          = bus.InLevel;
  assign unused_pred_clear = bus.PredClear;
`endif

  // Block sequencer with registered register-write and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      reg_enable  <= 1'b0;
      reg_address <= '0;
      reg_data    <= '0;
      block_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      reg_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Address 0 write also clears indexes 1..63 in the register.
            reg_enable  <= 1'b1;
            reg_address <= '0;
            index       <= 7'd1;
            if (bus.InEob) begin
              reg_data <= '0;
              state    <= FLUSH;
            end else begin
              reg_data <= dc_value;
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (bus.InEob) begin
              state <= FLUSH;
            end else if (addr_sum <= 7'd63) begin
              reg_enable  <= 1'b1;
              reg_address <= addr_sum[5:0];
              reg_data    <= bus.InLevel;
              index       <= addr_sum + 7'd1;
              if (addr_sum == 7'd63) begin
                state <= FLUSH;
              end
            end else begin
              overrun <= 1'b1;
              state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state       <= FULL;
          block_valid <= 1'b1;
        end
        FULL: begin
          if (bus.BlockAck) begin
            state       <= IDLE;
            block_valid <= 1'b0;
            index       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_ziguzagu_ctrl.sv
// Directed bench for jpeg_ziguzagu_ctrl: a small token model pushes the
// expected register writes to a queue, and each observed write pops one.
module tb_jpeg_ziguzagu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jpeg_ziguzagu_ctrl_if bus ();

  jpeg_ziguzagu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected writes, packed as {addr[5:0], data[15:0]}.
  logic [21:0] exp_q[$];

  // Token model state.
  int          m_idx  = 0;
  bit          m_dc   = 1'b1;
  logic [15:0] m_pred = '0;
  logic        m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and account for any register write that appeared.
  task automatic tick();
    logic [21:0] e;
    @(posedge clk);
    #1;
    if (bus.RegEnable === 1'b1) begin
      chk("write_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", {26'd0, bus.RegAddress}, {26'd0, e[21:16]});
        chk("write_data", {16'd0, bus.RegData}, {16'd0, e[15:0]});
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.InReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, bus.InReady}, 32'd1);
  endtask

  task automatic push_write(input int addr, input logic [15:0] data);
    logic [5:0] a;
    a = addr[5:0];
    exp_q.push_back({a, data});
  endtask

  // Drive one token through its accepting edge, updating the model first.
  task automatic send(input int run, input logic [15:0] lvl, input bit eob, input bit pclr);
    int          addr;
    logic [15:0] dc;
    wait_ready();
    if (m_dc) begin
      if (eob) begin
        push_write(0, 16'h0000);
      end else begin
`ifdef JPEG_ZIGUZAGU_CTRL_DCPRED_EN
        dc     = (pclr ? 16'h0000 : m_pred) + lvl;
        m_pred = dc;
`else
        dc = lvl;
`endif
        push_write(0, dc);
      end
      m_idx = 1;
      m_dc  = 1'b0;
    end else if (!eob) begin
      addr = m_idx + run;
      if (addr <= 63) begin
        push_write(addr, lvl);
        m_idx = addr + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    bus.InValid   = 1'b1;
    bus.InRun     = run[3:0];
    bus.InLevel   = lvl;
    bus.InEob     = eob;
    bus.PredClear = pclr;
    tick();
    bus.InValid   = 1'b0;
    bus.InEob     = 1'b0;
    bus.PredClear = 1'b0;
  endtask

  task automatic pred_clear();
    bus.PredClear = 1'b1;
    tick();
    bus.PredClear = 1'b0;
    m_pred = '0;
  endtask

  // Called right after the final token's accepting edge.
  task automatic finish_block(input string tag);
    chk({tag, "_bv_not_yet"}, {31'd0, bus.BlockValid}, 32'd0);
    chk({tag, "_ready_low_flush"}, {31'd0, bus.InReady}, 32'd0);
    tick();
    chk({tag, "_bv_rise"}, {31'd0, bus.BlockValid}, 32'd1);
    chk({tag, "_all_writes_seen"}, exp_q.size(), 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus.Overrun}, {31'd0, m_ovf});
    tick();
    tick();
    chk({tag, "_bv_hold"}, {31'd0, bus.BlockValid}, 32'd1);
    chk({tag, "_ready_low_full"}, {31'd0, bus.InReady}, 32'd0);
    bus.BlockAck = 1'b1;
    tick();
    bus.BlockAck = 1'b0;
    chk({tag, "_bv_fall"}, {31'd0, bus.BlockValid}, 32'd0);
    chk({tag, "_ready_after_ack"}, {31'd0, bus.InReady}, 32'd1);
    m_dc  = 1'b1;
    m_idx = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.InReady}, 32'd0);
    chk({tag, "_reg_en"}, {31'd0, bus.RegEnable}, 32'd0);
    chk({tag, "_reg_addr"}, {26'd0, bus.RegAddress}, 32'd0);
    chk({tag, "_reg_data"}, {16'd0, bus.RegData}, 32'd0);
    chk({tag, "_bv"}, {31'd0, bus.BlockValid}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus.Overrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.InValid   = 1'b0;
    bus.InRun     = '0;
    bus.InLevel   = '0;
    bus.InEob     = 1'b0;
    bus.PredClear = 1'b0;
    bus.BlockAck  = 1'b0;

    // Reset state.
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.InReady}, 32'd1);

    // Basic block: DC, two ACs, EOB.
    send(0, 16'd5, 1'b0, 1'b0);
    send(0, 16'd3, 1'b0, 1'b0);
    send(2, 16'hFFFF, 1'b0, 1'b0);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("basic");

    // BlockAck outside FULL has no effect on a fresh block.
    bus.BlockAck = 1'b1;
    tick();
    bus.BlockAck = 1'b0;
    chk("stray_ack_ready", {31'd0, bus.InReady}, 32'd1);

    // Full block of 64 back-to-back tokens, no EOB.
    for (int i = 0; i < 64; i++) begin
      send(0, 16'(i), 1'b0, 1'b0);
    end
    finish_block("full64");

    // ZRL tokens walking past index 63.
    send(0, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(15, 16'd0, 1'b0, 1'b0);
    end
    finish_block("overrun");

    // EOB as the very first token.
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("eob_first");

    // DC differences across three blocks, with a restart clear between.
    pred_clear();
    send(0, 16'd10, 1'b0, 1'b0);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("dc_a");
    send(0, 16'hFFFC, 1'b0, 1'b0);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("dc_b");
    pred_clear();
    send(0, 16'd6, 1'b0, 1'b0);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("dc_c");

    // Clear coincident with a DC acceptance.
    send(0, 16'd7, 1'b0, 1'b1);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("dc_coinc");

    // Reset in the middle of a block, then a normal block.
    send(0, 16'd2, 1'b0, 1'b0);
    send(0, 16'd4, 1'b0, 1'b0);
    send(1, 16'd5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst    = 1'b0;
    m_dc   = 1'b1;
    m_idx  = 0;
    m_pred = '0;
    m_ovf  = 1'b0;
    send(0, 16'd9, 1'b0, 1'b0);
    send(0, 16'd0, 1'b1, 1'b0);
    finish_block("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
